// File: rtl/rs232_pkg.sv
// rs232_pkg: shared definitions for the RS-232 receiver and transmitter.
// Holds the baud constants, the divisor helper, the receiver state type and
// the 2-of-3 vote used when the RS232_RX_MAJORITY_EN build option is enabled.
package rs232_pkg;

  localparam int BAUD_FAST = 115200;
  localparam int BAUD_SLOW = 9600;

  // Receiver frame states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_t;

  // Clock cycles per bit, truncated integer division
  function automatic int div_of(input int clock_freq, input int baud);
    return clock_freq / baud;
  endfunction

  // 2-of-3 majority vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rs232_sync2.sv
// rs232_sync2: two-flop synchroniser for an asynchronous input pin.
// Reset value is a parameter so idle-high lines come out of reset idle.
module rs232_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rs232_rx.sv
// rs232_rx: 8N1 serial receiver with run-time baud select (fsel).
// Synchronises rxd, finds the start bit, samples each bit at its centre and
// strobes rdy for one cycle per good byte (ferr on a bad stop bit).
// Build option RS232_RX_MAJORITY_EN: each bit decision becomes a 2-of-3 vote
// of samples taken at counter values 2*s, s and 0 (s = div/16).
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int clock_freq = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fsel,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       rdy,
  output logic       ferr,
  output logic       busy
);

  localparam int DIV_FAST = div_of(clock_freq, BAUD_FAST);
  localparam int DIV_SLOW = div_of(clock_freq, BAUD_SLOW);
  localparam int CW       = $clog2(DIV_SLOW) + 1;

  localparam logic [CW-1:0] DIV_FAST_C = CW'(DIV_FAST);
  localparam logic [CW-1:0] DIV_SLOW_C = CW'(DIV_SLOW);

  logic            w_rxs;
  logic            w_bit;
  logic            w_expire;
  logic [CW-1:0]   w_div_sel;

  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_div;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_rdy;
  logic            r_ferr;
  logic            r_busy;

  rs232_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rxd),
    .o_q   (w_rxs)
  );

  assign w_div_sel = fsel ? DIV_SLOW_C : DIV_FAST_C;
  assign w_expire  = (r_cnt == '0);

`ifdef RS232_RX_MAJORITY_EN
  logic [CW-1:0] r_step;
  logic          r_v2;
  logic          r_v1;

  // Latch the vote spacing with the divisor and collect the two early samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= '0;
      r_v2   <= 1'b1;
      r_v1   <= 1'b1;
    end else begin
      if (r_state == ST_IDLE && !w_rxs) begin
        r_step <= w_div_sel >> 4;
      end
      if (r_state != ST_IDLE) begin
        if (r_cnt == (r_step << 1)) begin
          r_v2 <= w_rxs;
        end
        if (r_cnt == r_step) begin
          r_v1 <= w_rxs;
        end
      end
    end
  end

  assign w_bit = maj3(r_v2, r_v1, w_rxs);
`else
  assign w_bit = w_rxs;
`endif

  // Frame FSM: baud counting, bit sampling and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_div     <= DIV_FAST_C;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_rdy     <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rdy  <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!w_rxs) begin
            // Divisor is frozen for the whole frame; first wait is half a bit
            r_div   <= w_div_sel;
            r_cnt   <= (w_div_sel >> 1) - 1'b1;
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_expire) begin
            if (!w_bit) begin
              r_cnt     <= r_div - 1'b1;
              r_bit_idx <= '0;
              r_state   <= ST_DATA;
            end else begin
              // Line back high at start-bit centre: treat as a glitch
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (w_expire) begin
            r_shift <= {w_bit, r_shift[7:1]};
            r_cnt   <= r_div - 1'b1;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (w_expire) begin
            if (w_bit) begin
              r_data  <= r_shift;
              r_rdy   <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= ST_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          // A held-low line (break) must not be taken as a new start bit
          if (w_rxs) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = r_data;
  assign rdy      = r_rdy;
  assign ferr     = r_ferr;
  assign busy     = r_busy;

endmodule
